// File: rtl/sym_fir_serial_pkg.sv
// Shared definitions for the serial symmetric FIR: default widths, FSM encoding,
// width helper functions and the default 63-tap band coefficient set.
package sym_fir_serial_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  function automatic int clog2_int(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  // Pre-add adds one bit, the product adds COEF_W, and HALF sums add clog2(HALF).
  function automatic int acc_width(input int data_w, input int coef_w, input int half);
    return data_w + 1 + coef_w + clog2_int(half);
  endfunction

  // Outer tap (index 0) to centre tap (index 31), Q1.15; consumed by the coefficient loader.
  localparam logic signed [15:0] BAND_COEFS [32] = '{
    -16'sd12,  -16'sd15,  -16'sd18,  -16'sd20,  -16'sd19,  -16'sd14,  -16'sd4,   16'sd12,
     16'sd33,   16'sd57,   16'sd80,   16'sd98,   16'sd105,  16'sd97,   16'sd68,   16'sd15,
    -16'sd62,  -16'sd158, -16'sd262, -16'sd358, -16'sd428, -16'sd449, -16'sd401, -16'sd263,
    -16'sd23,   16'sd320,  16'sd754,  16'sd1255, 16'sd1788, 16'sd2310, 16'sd2777, 16'sd3143
  };

endpackage

// File: rtl/sym_fir_serial_mac_unit.sv
// Datapath for one folded tap pair: pre-adder, single multiplier and the
// full-precision accumulator with synchronous clear and accumulate enable.
module fir_mac_unit
  import sym_fir_serial_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = acc_width(DEF_DATA_W, DEF_COEF_W, 32)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     acc_en_i,
  input  logic                     fold_i,
  input  logic signed [DATA_W-1:0] x_a_i,
  input  logic signed [DATA_W-1:0] x_b_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  localparam int PROD_W = DATA_W + 1 + COEF_W;

  logic signed [DATA_W:0]   pre_add;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;

  // NOTE: every variable gets a full default assignment first so no path leaves it unassigned (no latch).
  always_comb begin
    pre_add = (DATA_W + 1)'(x_a_i);
    if (fold_i) pre_add = pre_add + (DATA_W + 1)'(x_b_i);
    prod = PROD_W'(pre_add) * PROD_W'(coef_i);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (acc_en_i) begin
      acc_q <= acc_q + ACC_W'(prod);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/sym_fir_serial.sv
// Time-multiplexed symmetric FIR for one equalizer band: one MAC per folded tap
// pair, runtime-loadable coefficients, rounded and saturated output.
module sym_fir_serial
  import sym_fir_serial_pkg::*;
#(
  parameter int NUM_TAPS = 63,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int ADDR_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable,
  input  logic signed [DATA_W-1:0] filter_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic signed [DATA_W-1:0] filter_out,
  output logic                     out_valid
);

  localparam int HALF  = (NUM_TAPS + 1) / 2;
  localparam int ACC_W = acc_width(DATA_W, COEF_W, HALF);

  localparam logic [ADDR_W-1:0]      K_LAST = ADDR_W'(HALF - 1);
  localparam logic signed [ACC_W-1:0] RND   = {{(ACC_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_e                   state_q;
  logic [ADDR_W-1:0]        k_q;
  logic signed [DATA_W-1:0] x_q    [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_q [HALF];
  logic signed [DATA_W-1:0] filter_out_q;

  logic                     accept;
  logic                     coef_wr;
  logic                     fold;
  logic signed [DATA_W-1:0] x_a;
  logic signed [DATA_W-1:0] x_b;
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  rnd_sum;
  logic signed [ACC_W-1:0]  y_wide;
  logic signed [DATA_W-1:0] y_sat;

  assign in_ready   = (state_q == ST_IDLE) || (state_q == ST_OUT);
  assign out_valid  = (state_q == ST_OUT);
  assign filter_out = filter_out_q;
  assign accept     = clk_enable && in_valid && in_ready;
  assign coef_wr    = clk_enable && coef_we && in_ready;
  assign fold       = (k_q != K_LAST);

  // Tap k pairs with its mirror NUM_TAPS-1-k; the compare chain avoids indexing past the array.
  always_comb begin
    x_a      = '0;
    x_b      = '0;
    coef_sel = '0;
    for (int i = 0; i < HALF; i++) begin
      if (k_q == ADDR_W'(i)) begin
        x_a      = x_q[i];
        x_b      = x_q[NUM_TAPS-1-i];
        coef_sel = coef_q[i];
      end
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst),
    .clr_i    (accept),
    .acc_en_i (clk_enable && (state_q == ST_MAC)),
    .fold_i   (fold),
    .x_a_i    (x_a),
    .x_b_i    (x_b),
    .coef_i   (coef_sel),
    .acc_o    (acc)
  );

  // Round half up toward +inf, then clamp to the output range.
  always_comb begin
    rnd_sum = acc + RND;
    y_wide  = rnd_sum >>> (COEF_W - 1);
    if (y_wide > Y_MAX)      y_sat = Y_MAX[DATA_W-1:0];
    else if (y_wide < Y_MIN) y_sat = Y_MIN[DATA_W-1:0];
    else                     y_sat = y_wide[DATA_W-1:0];
  end

  // NOTE: the delay line and coefficient bank are reset on purpose, so they stay flops rather than RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_TAPS; i++) x_q[i] <= '0;
    end else if (accept) begin
      x_q[0] <= filter_in;
      for (int i = 1; i < NUM_TAPS; i++) x_q[i] <= x_q[i-1];
    end
  end

  // Addresses at or above HALF match no entry and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < HALF; i++) coef_q[i] <= '0;
    end else begin
      for (int i = 0; i < HALF; i++) begin
        if (coef_wr && (coef_addr == ADDR_W'(i))) coef_q[i] <= coef_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      filter_out_q <= '0;
    end else if (clk_enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= ST_MAC;
            k_q     <= '0;
          end
        end
        ST_MAC: begin
          if (k_q == K_LAST) state_q <= ST_ROUND;
          else               k_q     <= k_q + ADDR_W'(1);
        end
        ST_ROUND: begin
          filter_out_q <= y_sat;
          state_q      <= ST_OUT;
        end
        ST_OUT: begin
          if (in_valid) begin
            state_q <= ST_MAC;
            k_q     <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sym_fir_serial.sv
// Self-checking bench for sym_fir_serial (7 taps): a direct-form reference model
// feeds a scoreboard of expected outputs and output latencies.
module tb_sym_fir_serial;

  logic               clk;
  logic               rst;
  logic               clk_enable;
  logic signed [15:0] filter_in;
  logic               in_valid;
  logic               in_ready;
  logic               coef_we;
  logic [5:0]         coef_addr;
  logic signed [15:0] coef_wdata;
  logic signed [15:0] filter_out;
  logic               out_valid;

  int errors   = 0;
  int n_checks = 0;
  int cyc      = 0;
  int exp_lat  = 6;

  logic signed [15:0] exp_q[$];
  int                 acc_edge_q[$];
  int                 acc_hist[$];
  int                 mdl_x[7];
  int                 mdl_c[4];
  logic signed [15:0] mon_e;
  int                 mon_t;

  sym_fir_serial #(
    .NUM_TAPS (7),
    .DATA_W   (16),
    .COEF_W   (16),
    .ADDR_W   (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_enable (clk_enable),
    .filter_in  (filter_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .filter_out (filter_out),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Direct-form 7-tap reference: shift in the sample, full convolution, round, saturate.
  function automatic logic signed [15:0] model_step(input logic signed [15:0] s);
    longint acc;
    for (int t = 6; t > 0; t--) mdl_x[t] = mdl_x[t-1];
    mdl_x[0] = int'(s);
    acc = 0;
    for (int t = 0; t < 7; t++) acc += longint'(mdl_c[(t < 4) ? t : 6 - t]) * longint'(mdl_x[t]);
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  // Scoreboard: push at each accept, pop and compare at each enabled out_valid cycle.
  always @(negedge clk) begin
    if (rst && clk_enable) begin
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_valid: got filter_out=%0d, expected no output", filter_out);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = acc_edge_q.pop_front();
          if (filter_out !== mon_e) begin
            errors++;
            $display("FAIL sample_value: got %0d, expected %0d", filter_out, mon_e);
          end
          n_checks++;
          if ((cyc + 1 - mon_t) != exp_lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected %0d", cyc + 1 - mon_t, exp_lat);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_step(filter_in));
        acc_edge_q.push_back(cyc + 1);
        acc_hist.push_back(cyc + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] s);
    logic rdy;
    logic done;
    done      = 1'b0;
    filter_in = s;
    in_valid  = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      rdy = in_ready && clk_enable;
      tick();
      done = rdy;
    end
    in_valid = 1'b0;
    if (!done) begin
      errors++;
      n_checks++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected accept");
    end
  endtask

  task automatic write_coef(input int addr, input int val, input bit taken);
    coef_addr  = 6'(addr);
    coef_wdata = 16'(val);
    coef_we    = 1'b1;
    tick();
    coef_we = 1'b0;
    if (taken) mdl_c[addr] = val;
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
    write_coef(0, c0, 1'b1);
    write_coef(1, c1, 1'b1);
    write_coef(2, c2, 1'b1);
    write_coef(3, c3, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b, expected 0", out_valid);
    end
    n_checks++;
    if (filter_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_filter_out: got %0d, expected 0", filter_out);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_impulse();
    load_coefs(1024, 2048, 4096, 8192);
    send(16'sd16384);
    for (int i = 0; i < 7; i++) send(16'sd0);
    drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL impulse_drain: got %0d pending outputs, expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base      = acc_hist.size();
    filter_in = 16'sd1000;
    in_valid  = 1'b1;
    for (int i = 0; i < 60 && acc_hist.size() < base + 4; i++) tick();
    in_valid = 1'b0;
    n_checks++;
    if (acc_hist.size() < base + 4) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d accepts, expected 4", acc_hist.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (acc_hist[base+i+1] - acc_hist[base+i] != 6) begin
          errors++;
          $display("FAIL b2b_spacing: got %0d cycles, expected 6", acc_hist[base+i+1] - acc_hist[base+i]);
        end
      end
    end
    drain();
  endtask

  task automatic test_clk_enable_stall();
    exp_lat = 9;
    send(-16'sd7000);
    repeat (2) tick();
    clk_enable = 1'b0;
    repeat (3) tick();
    clk_enable = 1'b1;
    drain();
    exp_lat = 6;
    n_checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain: got %0d pending outputs, expected 0", exp_q.size());
    end
  endtask

  task automatic test_coef_guard();
    send(16'sd8000);
    write_coef(0, 7777, 1'b0);
    drain();
    write_coef(4, 5555, 1'b0);
    send(16'sd8000);
    send(16'sd3000);
    drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL coef_guard_drain: got %0d pending outputs, expected 0", exp_q.size());
    end
  endtask

  task automatic test_rounding();
    load_coefs(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) send(16'sd0);
    send(16'sd16384);
    drain();
    n_checks++;
    if (filter_out !== 16'sd1) begin
      errors++;
      $display("FAIL round_pos: got %0d, expected 1", filter_out);
    end
    send(-16'sd16384);
    drain();
    n_checks++;
    if (filter_out !== 16'sd0) begin
      errors++;
      $display("FAIL round_neg: got %0d, expected 0", filter_out);
    end
  endtask

  task automatic test_saturation();
    load_coefs(16384, 16384, 16384, 16384);
    for (int i = 0; i < 7; i++) send(16'sd32767);
    drain();
    n_checks++;
    if (filter_out !== 16'sd32767) begin
      errors++;
      $display("FAIL sat_pos: got %0d, expected 32767", filter_out);
    end
    for (int i = 0; i < 7; i++) send(-16'sd32768);
    drain();
    n_checks++;
    if (filter_out !== -16'sd32768) begin
      errors++;
      $display("FAIL sat_neg: got %0d, expected -32768", filter_out);
    end
  endtask

  task automatic test_reset_mid_mac();
    int seen;
    load_coefs(1024, 2048, 4096, 8192);
    send(16'sd5000);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    exp_q.delete();
    acc_edge_q.delete();
    for (int i = 0; i < 7; i++) mdl_x[i] = 0;
    for (int i = 0; i < 4; i++) mdl_c[i] = 0;
    n_checks++;
    if (filter_out !== 16'sd0) begin
      errors++;
      $display("FAIL midrst_filter_out: got %0d, expected 0", filter_out);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in_ready: got %b, expected 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out_valid: got %b, expected 0", out_valid);
    end
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_output: got %0d out_valid cycles, expected 0", seen);
    end
    send(16'sd16384);
    for (int i = 0; i < 6; i++) send(16'sd0);
    drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_drain: got %0d pending outputs, expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst        = 1'b0;
    clk_enable = 1'b1;
    filter_in  = '0;
    in_valid   = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    for (int i = 0; i < 7; i++) mdl_x[i] = 0;
    for (int i = 0; i < 4; i++) mdl_c[i] = 0;

    test_reset();
    test_impulse();
    test_back_to_back();
    test_clk_enable_stall();
    test_coef_guard();
    test_rounding();
    test_saturation();
    test_reset_mid_mac();

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion by 300000 time units, expected summary");
    $fatal(1, "watchdog expired");
  end

endmodule
